// File: rtl/tc_sram_banked.sv
// tc_sram_banked: word-interleaved multi-bank SRAM with per-bank round-robin
// arbitration and a req/gnt/rvalid handshake.
//
// Each bank is a single-port array. Bank = low address bits, row = upper bits.
// Grants are combinational. Read data returns Latency cycles after the grant,
// flagged by rvalid_o.
//
// Optional feature macro: TC_SRAM_BANKED_WR_RESP_EN. When it is defined,
// writes also pulse rvalid_o Latency cycles after the grant, and rdata_o is
// left unchanged.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_i[p]          request, held until gnt_o[p]
//   gnt_o[p]          combinational grant
//   we_i[p]           1 = write, 0 = read
//   addr_i[p]         word address
//   wdata_i[p]        write data
//   be_i[p]           byte enables
//   rvalid_o[p]       response strobe
//   rdata_o[p]        read data; holds its value while rvalid_o is low
module tc_sram_banked #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned BankSel   = (NumBanks > 1) ? $clog2(NumBanks) : 0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  localparam int unsigned BankW     = (BankSel > 0) ? BankSel : 1;
  localparam int unsigned BankWords = NumWords / NumBanks;
  localparam int unsigned PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PipeW     = Latency * DataWidth;

  logic [NumPorts-1:0][BankW-1:0]                 bank_c;
  logic [NumPorts-1:0][AddrWidth-BankSel-1:0]     row_c;
  logic [NumBanks-1:0]                            bank_act_c;
  logic [NumBanks-1:0][PortW-1:0]                 bank_win_c;
  logic [NumBanks-1:0][DataWidth-1:0]             bank_rdata_c;

  // Address decode: bank from the low bits, row from the rest
  for (genvar p = 0; p < NumPorts; p++) begin : g_dec
    if (BankSel == 0) begin : g_one
      assign bank_c[p] = '0;
    end else begin : g_multi
      assign bank_c[p] = addr_i[p][BankW-1:0];
    end
    assign row_c[p] = addr_i[p][AddrWidth-1:BankSel];
  end

  // One arbiter and one single-port array per bank
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [PortW-1:0]     rr_q, rr_d;
    logic [PortW-1:0]     win_c, idx_c;
    logic                 act_c;
    logic                 we_c;
    logic [DataWidth-1:0] wmask_c;
    logic [DataWidth-1:0] mem_q [BankWords];

    // Round-robin search starting at rr_q, wrapping over all ports
    always_comb begin
      act_c = 1'b0;
      win_c = '0;
      idx_c = '0;
      rr_d  = rr_q;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        idx_c = PortW'((32'(rr_q) + i) % NumPorts);
        if (!act_c && rst_ni && req_i[idx_c] && (bank_c[idx_c] == BankW'(b))) begin
          act_c = 1'b1;
          win_c = idx_c;
        end
      end
      if (act_c) begin
        rr_d = PortW'((32'(win_c) + 1) % NumPorts);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q <= '0;
      end else begin
        rr_q <= rr_d;
      end
    end

    // Byte enables expanded to a bit mask
    for (genvar k = 0; k < DataWidth; k++) begin : g_mask
      assign wmask_c[k] = be_i[win_c][k / ByteWidth];
    end

    assign we_c = act_c & we_i[win_c];

    // Array contents are deliberately outside the reset domain
    always_ff @(posedge clk_i) begin
      if (we_c) begin
        mem_q[row_c[win_c]] <= (mem_q[row_c[win_c]] & ~wmask_c) |
                               (wdata_i[win_c] & wmask_c);
      end
    end

    assign bank_act_c[b]   = act_c;
    assign bank_win_c[b]   = win_c;
    assign bank_rdata_c[b] = mem_q[row_c[win_c]];
  end

  // Per-port grant and response pipeline
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic                              rd_gnt_c;
    logic [Latency-1:0]                rv_q, rv_d;
    logic [Latency-1:0][DataWidth-1:0] sd_q, sd_d;

    assign gnt_o[p]  = bank_act_c[bank_c[p]] && (bank_win_c[bank_c[p]] == PortW'(p));
    assign rd_gnt_c  = gnt_o[p] & ~we_i[p];

    // Data stages shift freely; only the output stage holds when no read lands
    always_comb begin
      rv_d = Latency'({rv_q, rd_gnt_c});
      sd_d = PipeW'({sd_q, bank_rdata_c[bank_c[p]]});
      if (!rv_d[Latency-1]) begin
        sd_d[Latency-1] = sd_q[Latency-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rv_q <= '0;
        sd_q <= '0;
      end else begin
        rv_q <= rv_d;
        sd_q <= sd_d;
      end
    end

`ifdef TC_SRAM_BANKED_WR_RESP_EN
    logic [Latency-1:0] wv_q, wv_d;

    // Write acknowledge strobe, no data
    always_comb begin
      wv_d = Latency'({wv_q, gnt_o[p] & we_i[p]});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wv_q <= '0;
      end else begin
        wv_q <= wv_d;
      end
    end

    assign rvalid_o[p] = rv_q[Latency-1] | wv_q[Latency-1];
`else
    assign rvalid_o[p] = rv_q[Latency-1];
`endif
    assign rdata_o[p] = sd_q[Latency-1];
  end

endmodule
